// File: rtl/door_controller.sv
// Elevator car-door controller: timed open/dwell/close strokes, obstruction
// reopen with a bounded budget and nudge close, and a sticky motion-interlock fault.
module door_controller #(
  parameter int FLOORS      = 7,
  parameter int FLOOR_W     = 3,
  parameter int OPEN_TIME   = 5,
  parameter int TRAVEL_TIME = 2,
  parameter int MAX_REOPEN  = 3
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               enable,
  input  logic               moving,
  input  logic [FLOOR_W-1:0] currentFloor,
  input  logic [1:0]         currentDirection,
  input  logic [1:0]         currentFloorButton,
  input  logic [FLOORS+2:1]  internalButton,
  input  logic               obstruction,
  output logic [1:0]         doorState,
  output logic               doorClosed,
  output logic               served,
  output logic               nudge,
  output logic               fault
);

  localparam int REOPEN_W = (MAX_REOPEN < 1) ? 1 : $clog2(MAX_REOPEN + 1);
  localparam int CLOSE_B  = FLOORS + 1;
  localparam int OPEN_B   = FLOORS + 2;

  localparam logic [REOPEN_W-1:0] REOPEN_MAX = REOPEN_W'(MAX_REOPEN);
  localparam logic [31:0]         OPEN_CNT   = 32'(OPEN_TIME);
  localparam logic [31:0]         TRAVEL_CNT = 32'(TRAVEL_TIME);

  typedef enum logic [1:0] {
    CLOSED  = 2'b00,
    OPENING = 2'b01,
    OPEN    = 2'b10,
    CLOSING = 2'b11
  } doorState_t;

  doorState_t          state, stateNext;
  logic [31:0]         cnt, cntNext;
  logic [REOPEN_W-1:0] reopenCnt, reopenNext;
  logic                nudgeQ, nudgeNext;
  logic                servedQ, servedNext;
  logic                doorClosedQ;
  logic                faultQ;

  logic carCall;
  logic hallMatch;
  logic openReq;
  logic reopenReq;
  logic openB;
  logic closeB;
  logic expire;

  // Request decode: a floor value outside 1..FLOORS selects no car call
  always_comb begin
    carCall = 1'b0;
    for (int f = 1; f <= FLOORS; f++) begin
      if (currentFloor == FLOOR_W'(f)) carCall = internalButton[f];
    end
  end

  always_comb begin
    case (currentDirection)
      2'b10:   hallMatch = currentFloorButton[1];
      2'b01:   hallMatch = currentFloorButton[0];
      2'b00:   hallMatch = |currentFloorButton;
      default: hallMatch = 1'b0;
    endcase
  end

  assign openB     = internalButton[OPEN_B];
  assign closeB    = internalButton[CLOSE_B];
  assign openReq   = !moving && (carCall || hallMatch);
  assign reopenReq = openReq || openB || obstruction;
  assign expire    = (cnt <= 32'd1);

  // State register; fault is sampled every clk, everything else moves on ticks
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state       <= CLOSED;
      cnt         <= '0;
      reopenCnt   <= '0;
      nudgeQ      <= 1'b0;
      servedQ     <= 1'b0;
      doorClosedQ <= 1'b1;
      faultQ      <= 1'b0;
    end else begin
      state       <= stateNext;
      cnt         <= cntNext;
      reopenCnt   <= reopenNext;
      nudgeQ      <= nudgeNext;
      servedQ     <= servedNext;
      doorClosedQ <= (stateNext == CLOSED);
      faultQ      <= faultQ || (moving && (state != CLOSED));
    end
  end

  // Next-state logic
  always_comb begin
    stateNext  = state;
    cntNext    = cnt;
    reopenNext = reopenCnt;
    nudgeNext  = nudgeQ;
    servedNext = 1'b0;
    if (enable) begin
      case (state)
        CLOSED: begin
          if (openReq || (openB && !moving)) begin
            stateNext = OPENING;
            cntNext   = TRAVEL_CNT;
          end
        end
        OPENING: begin
          if (expire) begin
            stateNext  = OPEN;
            cntNext    = OPEN_CNT;
            servedNext = 1'b1;
          end else begin
            cntNext = cnt - 32'd1;
          end
        end
        OPEN: begin
          if (reopenReq) begin
            cntNext = OPEN_CNT;
          end else if (closeB || expire) begin
            stateNext = CLOSING;
            cntNext   = TRAVEL_CNT;
          end else begin
            cntNext = cnt - 32'd1;
          end
        end
        CLOSING: begin
          // A reopen beats the completion tick while budget remains
          if (reopenReq && (reopenCnt < REOPEN_MAX)) begin
            stateNext  = OPENING;
            cntNext    = TRAVEL_CNT;
            reopenNext = reopenCnt + REOPEN_W'(1);
          end else begin
            if (reopenReq) nudgeNext = 1'b1;
            if (expire) begin
              stateNext  = CLOSED;
              cntNext    = '0;
              reopenNext = '0;
              nudgeNext  = 1'b0;
            end else begin
              cntNext = cnt - 32'd1;
            end
          end
        end
        default: begin
          stateNext = CLOSED;
          cntNext   = '0;
        end
      endcase
    end
  end

  // Outputs are all registered
  always_comb begin
    doorState  = state;
    doorClosed = doorClosedQ;
    served     = servedQ;
    nudge      = nudgeQ;
    fault      = faultQ;
  end

endmodule

// File: tb/tb_door_controller.sv
// Randomized and scenario stimulus for door_controller, checked every clk
// against a tick-timeline reference model of the door.
module tb_door_controller;

  localparam int FLOORS      = 7;
  localparam int FLOOR_W     = 3;
  localparam int OPEN_TIME   = 5;
  localparam int TRAVEL_TIME = 2;
  localparam int MAX_REOPEN  = 3;
  localparam int CLOSE_B     = FLOORS + 1;
  localparam int OPEN_B      = FLOORS + 2;

  localparam int PH_CLOSED  = 0;
  localparam int PH_OPENING = 1;
  localparam int PH_OPEN    = 2;
  localparam int PH_CLOSING = 3;

  logic               clk = 1'b0;
  logic               reset = 1'b1;
  logic               enable = 1'b0;
  logic               moving = 1'b0;
  logic [FLOOR_W-1:0] currentFloor = '0;
  logic [1:0]         currentDirection = '0;
  logic [1:0]         currentFloorButton = '0;
  logic [FLOORS+2:1]  internalButton = '0;
  logic               obstruction = 1'b0;
  logic [1:0]         doorState;
  logic               doorClosed;
  logic               served;
  logic               nudge;
  logic               fault;

  door_controller #(
    .FLOORS(FLOORS), .FLOOR_W(FLOOR_W), .OPEN_TIME(OPEN_TIME),
    .TRAVEL_TIME(TRAVEL_TIME), .MAX_REOPEN(MAX_REOPEN)
  ) dut (
    .clk(clk), .reset(reset), .enable(enable), .moving(moving),
    .currentFloor(currentFloor), .currentDirection(currentDirection),
    .currentFloorButton(currentFloorButton), .internalButton(internalButton),
    .obstruction(obstruction), .doorState(doorState), .doorClosed(doorClosed),
    .served(served), .nudge(nudge), .fault(fault)
  );

  always #5 clk = ~clk;

  int assertCount = 0;
  int failCount   = 0;

  // Reference model: phase plus the absolute tick number at which it ends
  int mPhase   = PH_CLOSED;
  int mEnd     = 0;
  int mTick    = 0;
  int mReopens = 0;
  bit mNudge   = 1'b0;
  bit mFault   = 1'b0;
  bit mServed  = 1'b0;

  task automatic checkVal(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    assertCount++;
    if (actual !== expected) begin
      failCount++;
      $display("FAIL %s: observed %0d, expected %0d (t=%0t)", tag, actual, expected, $time);
    end
  endtask

  function automatic bit specOpenReq();
    bit car;
    bit hall;
    int fl;
    car = 1'b0;
    fl  = int'(currentFloor);
    if (fl >= 1 && fl <= FLOORS) car = internalButton[fl];
    if (currentDirection == 2'b10)      hall = currentFloorButton[1];
    else if (currentDirection == 2'b01) hall = currentFloorButton[0];
    else if (currentDirection == 2'b00) hall = (currentFloorButton != 2'b00);
    else                                hall = 1'b0;
    return !moving && (car || hall);
  endfunction

  task automatic modelReset();
    mPhase = PH_CLOSED; mEnd = 0; mTick = 0; mReopens = 0;
    mNudge = 1'b0; mFault = 1'b0; mServed = 1'b0;
  endtask

  task automatic modelEdge();
    bit openReq, reopenReq, openB, closeB;
    openB     = internalButton[OPEN_B];
    closeB    = internalButton[CLOSE_B];
    openReq   = specOpenReq();
    reopenReq = openReq || openB || obstruction;
    if (moving && mPhase != PH_CLOSED) mFault = 1'b1;
    mServed = 1'b0;
    if (enable) begin
      mTick++;
      if (mPhase == PH_CLOSED) begin
        if (openReq || (openB && !moving)) begin
          mPhase = PH_OPENING; mEnd = mTick + TRAVEL_TIME;
        end
      end else if (mPhase == PH_OPENING) begin
        if (mTick == mEnd) begin
          mPhase = PH_OPEN; mEnd = mTick + OPEN_TIME; mServed = 1'b1;
        end
      end else if (mPhase == PH_OPEN) begin
        if (reopenReq) mEnd = mTick + OPEN_TIME;
        else if (closeB || mTick == mEnd) begin
          mPhase = PH_CLOSING; mEnd = mTick + TRAVEL_TIME;
        end
      end else begin
        if (reopenReq && mReopens < MAX_REOPEN) begin
          mPhase = PH_OPENING; mEnd = mTick + TRAVEL_TIME; mReopens++;
        end else begin
          if (reopenReq) mNudge = 1'b1;
          if (mTick == mEnd) begin
            mPhase = PH_CLOSED; mReopens = 0; mNudge = 1'b0;
          end
        end
      end
    end
  endtask

  task automatic compareAll();
    checkVal("doorState", doorState, mPhase);
    checkVal("doorClosed", doorClosed, (mPhase == PH_CLOSED));
    checkVal("served", served, mServed);
    checkVal("nudge", nudge, mNudge);
    checkVal("fault", fault, mFault);
  endtask

  // Inputs are set just after a negedge; this advances one clk and checks
  task automatic step();
    @(posedge clk);
    if (reset) modelEdge();
    #1 compareAll();
    @(negedge clk);
  endtask

  task automatic doReset();
    reset = 1'b0;
    #1;
    modelReset();
    compareAll();
    @(posedge clk);
    #1 compareAll();
    @(negedge clk);
    reset = 1'b1;
  endtask

  task automatic setIdle();
    enable = 1'b0; moving = 1'b0; obstruction = 1'b0;
    currentFloor = '0; currentDirection = '0; currentFloorButton = '0;
    internalButton = '0;
  endtask

  task automatic runTicks(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  int expCar[10]   = '{1, 1, 2, 2, 2, 2, 2, 3, 3, 0};
  int expClose[7]  = '{1, 1, 2, 2, 3, 3, 0};
  int nudgeSeen;
  int enPct;

  initial begin
    setIdle();
    @(negedge clk);
    doReset();

    // Reset then idle for 20 ticks
    enable = 1'b1;
    runTicks(20);
    checkVal("idleState", doorState, PH_CLOSED);

    // Car call at floor 3
    currentFloor = 3'd3;
    for (int k = 0; k < 10; k++) begin
      internalButton[3] = (k == 0);
      step();
      checkVal("carCallState", doorState, expCar[k]);
      checkVal("carCallServed", served, (k == 2));
    end

    // Close button on the second open tick
    currentFloor = '0;
    for (int k = 0; k < 7; k++) begin
      internalButton[OPEN_B]  = (k == 0);
      internalButton[CLOSE_B] = (k == 4);
      step();
      checkVal("closeBtnState", doorState, expClose[k]);
    end

    // Open and close together hold the door open and reload the dwell
    for (int k = 0; k < 12; k++) begin
      internalButton[OPEN_B]  = (k == 0) || (k == 4);
      internalButton[CLOSE_B] = (k == 4);
      step();
      if (k == 4) checkVal("bothBtnHold", doorState, PH_OPEN);
      if (k == 8) checkVal("reloadDwell", doorState, PH_OPEN);
      if (k == 9) checkVal("reloadExpire", doorState, PH_CLOSING);
    end
    checkVal("bothBtnClosed", doorState, PH_CLOSED);

    // Obstruction during every closing stroke exhausts the budget into nudge
    currentFloor = 3'd5;
    nudgeSeen = 0;
    for (int k = 0; k < 40; k++) begin
      internalButton[5] = (k == 0);
      obstruction = (mPhase == PH_CLOSING);
      step();
      if (nudge) nudgeSeen++;
    end
    obstruction = 1'b0;
    checkVal("nudgeSeen", (nudgeSeen > 0), 1);
    checkVal("nudgeClosed", doorState, PH_CLOSED);
    checkVal("nudgeCleared", nudge, 0);

    // Direction filter
    setIdle();
    enable = 1'b1;
    currentDirection = 2'b10; currentFloorButton = 2'b01;
    for (int k = 0; k < 5; k++) begin
      step();
      checkVal("upIgnoresDown", doorState, PH_CLOSED);
    end
    currentFloorButton = 2'b11;
    step();
    checkVal("upMatchesBoth", doorState, PH_OPENING);
    currentFloorButton = 2'b00;
    runTicks(12);
    currentDirection = 2'b00; currentFloorButton = 2'b01;
    step();
    checkVal("stopAnyHall", doorState, PH_OPENING);
    currentFloorButton = 2'b00;
    runTicks(12);

    // Motion interlock during OPEN
    currentFloor = 3'd2;
    for (int k = 0; k < 13; k++) begin
      internalButton[2] = (k == 0);
      moving = (k == 4);
      step();
      if (k == 4) checkVal("faultSet", fault, 1);
    end
    checkVal("faultCycleDone", doorState, PH_CLOSED);
    checkVal("faultSticky", fault, 1);
    doReset();
    checkVal("faultCleared", fault, 0);

    // Randomized traffic with occasional asynchronous resets
    for (int blk = 0; blk < 20; blk++) begin
      enPct = (blk % 3 == 0) ? 100 : ((blk % 3 == 1) ? 50 : 30);
      for (int c = 0; c < 200; c++) begin
        enable             = ($urandom_range(0, 99) < enPct);
        moving             = ($urandom_range(0, 99) < 3);
        obstruction        = ($urandom_range(0, 99) < 10);
        currentFloor       = FLOOR_W'($urandom_range(0, 7));
        currentDirection   = 2'($urandom_range(0, 3));
        currentFloorButton = {($urandom_range(0, 99) < 10), ($urandom_range(0, 99) < 10)};
        for (int b = 1; b <= FLOORS + 2; b++) internalButton[b] = ($urandom_range(0, 99) < 5);
        if ($urandom_range(0, 999) < 3) doReset();
        else step();
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $finish;
  end

endmodule
